// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encodings, paddle codes, directions and helpers for the pong sequencer
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVE    = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  localparam logic [1:0] HIT_NONE = 2'b00;
  localparam logic [1:0] HIT_P1   = 2'b01;
  localparam logic [1:0] HIT_P2   = 2'b11;

  // dx: 0 moves toward P1 (left), 1 toward P2 (right); dy: 0 moves down (row+1), 1 up
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam logic [5:0] CENTRE = 6'd32;

  // Scores are 3-bit and stop at 7 rather than wrapping
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/pong_ball_step.sv
// rtl/pong_ball_step.sv - combinational bounce, miss and next-position logic for one frame tick
module pong_ball_step
  import pong_pkg::*;
#(
  parameter int FIELD_MAX = 63,
  parameter int P1_X      = 2,
  parameter int P2_X      = 61
) (
  input  logic [5:0] x,
  input  logic [5:0] y,
  input  logic       dx,
  input  logic       dy,
  input  logic [1:0] paddle,
  input  logic       wall,
  input  logic       fast,
  output logic [5:0] x_nxt,
  output logic [5:0] y_nxt,
  output logic       dx_nxt,
  output logic       dy_nxt,
  output logic       miss_p1,
  output logic       miss_p2
);

  localparam logic [5:0] P1_COL = 6'(P1_X);
  localparam logic [5:0] P2_COL = 6'(P2_X);
  localparam logic [5:0] Y_MAX  = 6'(FIELD_MAX);

  logic       hit_p1;
  logic       hit_p2;
  logic [5:0] room;

  // Bounce first, then detect a miss, then step in the updated direction; a fast
  // step shrinks to one pixel when a double step would jump over a paddle column
  always_comb begin
    hit_p1  = (paddle == HIT_P1) && (dx == DIR_LEFT);
    hit_p2  = (paddle == HIT_P2) && (dx == DIR_RIGHT);
    miss_p1 = (x == P1_COL) && (dx == DIR_LEFT)  && (paddle != HIT_P1);
    miss_p2 = (x == P2_COL) && (dx == DIR_RIGHT) && (paddle != HIT_P2);

    dx_nxt = dx;
    if (hit_p1) dx_nxt = DIR_RIGHT;
    if (hit_p2) dx_nxt = DIR_LEFT;
    dy_nxt = wall ? ~dy : dy;

    if (dx_nxt == DIR_RIGHT) begin
      room  = P2_COL - x;
      x_nxt = (fast && room >= 6'd2) ? x + 6'd2 : x + 6'd1;
    end else begin
      room  = x - P1_COL;
      x_nxt = (fast && room >= 6'd2) ? x - 6'd2 : x - 6'd1;
    end

    if (dy_nxt == DIR_DOWN) y_nxt = (y == Y_MAX) ? y : y + 6'd1;
    else                    y_nxt = (y == 6'd0)  ? y : y - 6'd1;
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - serve/play/point/game-over sequencer owning ball and scores; PONG_SPEEDUP_EN adds ball speed-up
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int FIELD_MAX   = 63,
  parameter int P1_X        = 2,
  parameter int P2_X        = 61,
  parameter int SERVE_TICKS = 32,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [1:0] paddle_collision,
  input  logic       wall_collision,
  output logic [5:0] ball_x,
  output logic [5:0] ball_y,
  output logic [2:0] sc1,
  output logic [2:0] sc2,
  output logic [2:0] state,
  output logic [1:0] winner,
  output logic       serve_dir
);

  localparam logic [7:0] LAST_TICK = 8'(SERVE_TICKS - 1);
  localparam logic [2:0] WIN_SC    = 3'(WIN_SCORE);

  state_t     st, st_nxt;
  logic       dx, dy, dx_n, dy_n;
  logic [5:0] bx_n, by_n;
  logic [2:0] sc1_n, sc2_n;
  logic [1:0] win_n;
  logic       sdir_n;
  logic [7:0] cnt, cnt_n;
  logic       scorer_p2, scorer_p2_n;

  logic [5:0] step_x, step_y;
  logic       step_dx, step_dy, miss_p1, miss_p2;
  logic       fast;

  assign state = st;

  pong_ball_step #(
    .FIELD_MAX(FIELD_MAX),
    .P1_X     (P1_X),
    .P2_X     (P2_X)
  ) u_step (
    .x      (ball_x),
    .y      (ball_y),
    .dx     (dx),
    .dy     (dy),
    .paddle (paddle_collision),
    .wall   (wall_collision),
    .fast   (fast),
    .x_nxt  (step_x),
    .y_nxt  (step_y),
    .dx_nxt (step_dx),
    .dy_nxt (step_dy),
    .miss_p1(miss_p1),
    .miss_p2(miss_p2)
  );

`ifdef PONG_SPEEDUP_EN
  logic [2:0] hits, hits_n;
  assign fast = (hits >= 3'd4);

  // Count paddle bounces (a dx flip) during play; a fresh serve starts slow again
  always_comb begin
    hits_n = hits;
    if (st == SERVE)
      hits_n = 3'd0;
    else if (st == PLAY && frame_tick && step_dx != dx && hits != 3'd7)
      hits_n = hits + 3'd1;
  end

  // Hit counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hits <= 3'd0;
    else        hits <= hits_n;
  end
`else
  assign fast = 1'b0;
`endif

  // Next-state, ball, score and serve decisions; the ball is centred whenever the
  // sequencer is (or is about to be) idle or serving
  always_comb begin
    st_nxt      = st;
    bx_n        = ball_x;
    by_n        = ball_y;
    dx_n        = dx;
    dy_n        = dy;
    sc1_n       = sc1;
    sc2_n       = sc2;
    win_n       = winner;
    sdir_n      = serve_dir;
    cnt_n       = cnt;
    scorer_p2_n = scorer_p2;
    case (st)
      IDLE: begin
        if (start) begin
          sc1_n  = 3'd0;
          sc2_n  = 3'd0;
          win_n  = 2'b00;
          st_nxt = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (cnt == LAST_TICK) begin
            cnt_n  = 8'd0;
            st_nxt = PLAY;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          dx_n = step_dx;
          dy_n = step_dy;
          if (miss_p1) begin
            scorer_p2_n = 1'b1;
            st_nxt      = POINT;
          end else if (miss_p2) begin
            scorer_p2_n = 1'b0;
            st_nxt      = POINT;
          end else begin
            bx_n = step_x;
            by_n = step_y;
          end
        end
      end
      POINT: begin
        if (scorer_p2) sc2_n = sat_inc3(sc2);
        else           sc1_n = sat_inc3(sc1);
        if ((scorer_p2 ? sc2_n : sc1_n) == WIN_SC) begin
          win_n  = scorer_p2 ? 2'b10 : 2'b01;
          st_nxt = GAMEOVER;
        end else begin
          sdir_n = scorer_p2 ? DIR_LEFT : DIR_RIGHT;
          st_nxt = SERVE;
        end
      end
      GAMEOVER: begin
        if (start) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
    if (st_nxt == IDLE || st_nxt == SERVE) begin
      bx_n = CENTRE;
      by_n = CENTRE;
    end
    if (st_nxt == SERVE) dx_n = sdir_n;
  end

  // State, ball and score registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      ball_x    <= CENTRE;
      ball_y    <= CENTRE;
      dx        <= DIR_RIGHT;
      dy        <= DIR_DOWN;
      sc1       <= 3'd0;
      sc2       <= 3'd0;
      winner    <= 2'b00;
      serve_dir <= 1'b1;
      cnt       <= 8'd0;
      scorer_p2 <= 1'b0;
    end else begin
      st        <= st_nxt;
      ball_x    <= bx_n;
      ball_y    <= by_n;
      dx        <= dx_n;
      dy        <= dy_n;
      sc1       <= sc1_n;
      sc2       <= sc2_n;
      winner    <= win_n;
      serve_dir <= sdir_n;
      cnt       <= cnt_n;
      scorer_p2 <= scorer_p2_n;
    end
  end

endmodule
